// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial 4-bit adder driver.
//   FRAME_BITS  : bits per serial frame (must match the adder, only 4 supported)
//   PHASE_W     : width of the in-frame phase counter
//   phase_t     : phase counter type
//   frame_tag_t : per-frame tag {valid, a, b} that travels alongside a frame
//   ref_add()   : reference addition returning {carry_out, sum}
package serial_adder_pkg;

    localparam int FRAME_BITS = 4;
    localparam int PHASE_W    = 2;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef struct packed {
        logic                  valid;
        logic [FRAME_BITS-1:0] a;
        logic [FRAME_BITS-1:0] b;
    } frame_tag_t;

    function automatic logic [FRAME_BITS:0] ref_add(input logic [FRAME_BITS-1:0] a,
                                                    input logic [FRAME_BITS-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/serial_frame_capture.sv
// Collect end of the serial adder protocol.
// Samples OUTP on the four edges after each frame's bits go out (LSB first),
// samples OVERFLW one edge later, and publishes {res_ovf, res_sum} with a
// one-cycle res_valid pulse for frames that carried a real operand pair.
// Optional macro SERIAL_OPERAND_DRIVER_CHECK_EN adds an operand queue and a
// sticky arithmetic self-check (chk_err); without it chk_err is tied to 0.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   phase             : transmit phase of the current cycle (0..3)
//   tag_in            : tag of the frame being loaded at the phase-3 edge
//   outp, overflw     : serial sum bit and overflow flag from the adder
//   res_valid         : one-cycle result strobe
//   res_sum, res_ovf  : reassembled sum and carry-out, held until next result
//   chk_err           : sticky self-check error
module serial_frame_capture
    import serial_adder_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  phase_t                phase,
    input  frame_tag_t            tag_in,
    input  logic                  outp,
    input  logic                  overflw,
    output logic                  res_valid,
    output logic [FRAME_BITS-1:0] res_sum,
    output logic                  res_ovf,
    output logic                  chk_err
);

    localparam phase_t LAST_PHASE = phase_t'(FRAME_BITS - 1);
    // The edge ending phase 1 is both the OVERFLW sample of frame n and the
    // bit-0 sample of frame n+1.
    localparam phase_t DONE_PHASE = phase_t'(1);

    logic [FRAME_BITS-1:0] cap_sum;
    phase_t                bit_idx;
    logic                  tag_done;

    // OUTP lags the line by one edge, so the bit index trails the phase by one.
    assign bit_idx = phase - phase_t'(1);

`ifdef SERIAL_OPERAND_DRIVER_CHECK_EN
    frame_tag_t            tag_q0;
    frame_tag_t            tag_q1;
    logic [FRAME_BITS:0]   res_exp;

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q0  <= '0;
            tag_q1  <= '0;
            res_exp <= '0;
            chk_err <= 1'b0;
        end else begin
            if (phase == LAST_PHASE) begin
                tag_q1 <= tag_q0;
                tag_q0 <= tag_in;
            end
            if (phase == DONE_PHASE)
                res_exp <= ref_add(tag_q1.a, tag_q1.b);
            if (res_valid && ({res_ovf, res_sum} != res_exp))
                chk_err <= 1'b1;
        end
    end

    assign tag_done = tag_q1.valid;
`else
    logic tag_q0;
    logic tag_q1;
    logic unused_ops;

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q0 <= 1'b0;
            tag_q1 <= 1'b0;
        end else if (phase == LAST_PHASE) begin
            tag_q1 <= tag_q0;
            tag_q0 <= tag_in.valid;
        end
    end

    assign tag_done   = tag_q1;
    assign chk_err    = 1'b0;
    assign unused_ops = ^{tag_in.a, tag_in.b};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_sum   <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_ovf   <= 1'b0;
        end else begin
            cap_sum[bit_idx] <= outp;
            res_valid        <= 1'b0;
            if (phase == DONE_PHASE) begin
                res_valid <= tag_done;
                if (tag_done) begin
                    res_sum <= cap_sum;
                    res_ovf <= overflw;
                end
            end
        end
    end

endmodule

// File: rtl/serial_operand_driver.sv
// Transmit end of the serial adder protocol plus the result collector.
// Accepts 4-bit operand pairs over valid/ready into a one-entry holding
// register and shifts them out LSB-first on LINE1/LINE2, one frame every four
// clocks. Frames with no pending pair transmit 0+0 so the adder stays in phase.
// Optional macro SERIAL_OPERAND_DRIVER_CHECK_EN enables the result self-check.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   in_valid, in_ready   : operand handshake (in_ready is combinational)
//   in_a, in_b           : operands
//   LINE1, LINE2         : serial operand bits to the adder
//   OUTP, OVERFLW        : serial sum bit and overflow flag from the adder
//   res_valid            : one-cycle result strobe
//   res_sum, res_ovf     : reassembled sum and carry-out
//   chk_err              : sticky self-check error (0 when check disabled)
module serial_operand_driver
    import serial_adder_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAME_BITS-1:0] in_a,
    input  logic [FRAME_BITS-1:0] in_b,
    output logic                  LINE1,
    output logic                  LINE2,
    input  logic                  OUTP,
    input  logic                  OVERFLW,
    output logic                  res_valid,
    output logic [FRAME_BITS-1:0] res_sum,
    output logic                  res_ovf,
    output logic                  chk_err
);

    localparam phase_t LAST_PHASE = phase_t'(FRAME_BITS - 1);

    phase_t                phase;
    logic [FRAME_BITS-1:0] hold_a;
    logic [FRAME_BITS-1:0] hold_b;
    logic                  hold_valid;
    logic [FRAME_BITS-1:0] sh_a;
    logic [FRAME_BITS-1:0] sh_b;
    logic                  frame_end;
    logic                  accept;
    frame_tag_t            tag_in;

    assign frame_end = (phase == LAST_PHASE);
    // Hold drains into the shifters on the phase-3 edge, so a full hold can
    // still take a new pair on that same edge.
    assign in_ready  = !hold_valid || frame_end;
    assign accept    = in_valid && in_ready;

    assign LINE1  = sh_a[0];
    assign LINE2  = sh_b[0];
    assign tag_in = {hold_valid, hold_a, hold_b};

    always_ff @(posedge clock) begin
        if (reset) begin
            phase      <= '0;
            hold_a     <= '0;
            hold_b     <= '0;
            hold_valid <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
        end else begin
            phase <= phase + phase_t'(1);

            if (frame_end) begin
                sh_a <= hold_valid ? hold_a : '0;
                sh_b <= hold_valid ? hold_b : '0;
            end else begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
            end

            if (accept) begin
                hold_a     <= in_a;
                hold_b     <= in_b;
                hold_valid <= 1'b1;
            end else if (frame_end) begin
                hold_valid <= 1'b0;
            end
        end
    end

    serial_frame_capture u_capture (
        .clock     (clock),
        .reset     (reset),
        .phase     (phase),
        .tag_in    (tag_in),
        .outp      (OUTP),
        .overflw   (OVERFLW),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_ovf   (res_ovf),
        .chk_err   (chk_err)
    );

endmodule

// File: tb/tb_serial_operand_driver.sv
// Directed bench for serial_operand_driver with a behavioural serial adder.
// Cycle numbers count from the first cycle after the last reset edge.
module tb_serial_operand_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_a = 4'd0;
    logic [3:0] in_b = 4'd0;
    logic       in_ready;
    logic       LINE1;
    logic       LINE2;
    logic       OUTP;
    logic       OVERFLW;
    logic       res_valid;
    logic [3:0] res_sum;
    logic       res_ovf;
    logic       chk_err;

    int         checks = 0;
    int         errors = 0;
    int         cyc;
    logic       force_zero = 1'b0;

    // behavioural serial adder state
    logic [1:0] m_ph;
    logic       m_c;
    logic       m_cin;
    logic       m_s;

    logic [3:0] ta;
    logic [3:0] tb;

    always #5 clock = ~clock;

    serial_operand_driver dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .LINE1     (LINE1),
        .LINE2     (LINE2),
        .OUTP      (OUTP),
        .OVERFLW   (OVERFLW),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_ovf   (res_ovf),
        .chk_err   (chk_err)
    );

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Adder: registered sum bit one edge after each line bit, carry-out of a
    // frame presented on OVERFLW one edge after the last sum bit.
    always @(posedge clock) begin
        if (reset) begin
            m_ph    <= 2'd0;
            m_c     <= 1'b0;
            OUTP    <= 1'b0;
            OVERFLW <= 1'b0;
        end else begin
            m_cin = (m_ph == 2'd0) ? 1'b0 : m_c;
            m_s   = LINE1 ^ LINE2 ^ m_cin;
            OUTP  <= force_zero ? 1'b0 : m_s;
            m_c   <= (LINE1 & LINE2) | (LINE1 & m_cin) | (LINE2 & m_cin);
            if (m_ph == 2'd0) OVERFLW <= m_c;
            m_ph  <= m_ph + 2'd1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic adv();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Frame 1 (cycles 4..7) carries the pair accepted in cycle 0.
    function automatic logic [1:0] exp_lines(input int c, input logic [3:0] a, input logic [3:0] b);
        if (c >= 4 && c <= 7) return {a[2'(c - 4)], b[2'(c - 4)]};
        return 2'b00;
    endfunction

    initial begin
        // ---- single pair 3+5, in_valid high through reset ----
        ta = 4'd3; tb = 4'd5;
        in_valid = 1'b1; in_a = ta; in_b = tb;
        do_reset();
        check("t1_ready_c0", in_ready, 1);
        check("t1_lines_c0", {LINE1, LINE2}, 0);
        check("t1_rv_c0", res_valid, 0);
        check("t1_sum_reset", res_sum, 0);
        adv();
        in_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) adv();
            check("t1_lines", {LINE1, LINE2}, exp_lines(c, ta, tb));
            check("t1_res_valid", res_valid, (c == 10));
            if (c == 2) check("t1_ready_full", in_ready, 0);
            if (c == 3) check("t1_ready_ph3", in_ready, 1);
            if (c >= 10) begin
                check("t1_sum", res_sum, 8);
                check("t1_ovf", res_ovf, 0);
            end
        end

        // ---- back-to-back 9+9 then 15+1, then 20 idle cycles ----
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
        do_reset();
        check("t2_ready_c0", in_ready, 1);
        adv();
        in_a = 4'd15; in_b = 4'd1;
        check("t2_ready_c1", in_ready, 0);
        adv();
        check("t2_ready_c2", in_ready, 0);
        adv();
        check("t2_ready_c3", in_ready, 1);
        adv();
        in_valid = 1'b0;
        check("t2_ready_c4", in_ready, 0);
        for (int c = 5; c <= 35; c++) begin
            adv();
            check("t2_res_valid", res_valid, (c == 10 || c == 14));
            if (c == 10) begin
                check("t2_sum_a", res_sum, 2);
                check("t2_ovf_a", res_ovf, 1);
            end
            if (c >= 14) begin
                check("t2_sum_b", res_sum, 0);
                check("t2_ovf_b", res_ovf, 1);
            end
            if (c >= 12) check("t3_idle_lines", {LINE1, LINE2}, 0);
        end

        // ---- reset in cycle 6 with a frame in flight ----
        in_valid = 1'b1; in_a = 4'd6; in_b = 4'd7;
        do_reset();
        adv();
        in_valid = 1'b0;
        repeat (5) adv();
        check("t4_lines_c6", {LINE1, LINE2}, 2'b11);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        check("t4_ready_after", in_ready, 1);
        check("t4_lines_after", {LINE1, LINE2}, 0);
        check("t4_rv_after", res_valid, 0);
        ta = 4'd10; tb = 4'd4;
        in_valid = 1'b1; in_a = ta; in_b = tb;
        adv();
        in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) adv();
            check("t4_lines", {LINE1, LINE2}, exp_lines(c, ta, tb));
            check("t4_res_valid", res_valid, (c == 10));
            if (c == 10) begin
                check("t4_sum", res_sum, 14);
                check("t4_ovf", res_ovf, 0);
            end
        end

        // ---- 1+2, with OUTP forced low when the self-check is built ----
        in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
        do_reset();
        adv();
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) adv();
`ifdef SERIAL_OPERAND_DRIVER_CHECK_EN
            if (c == 4) force_zero = 1'b1;
            if (c == 8) force_zero = 1'b0;
            check("t5_chk_err", chk_err, (c >= 11));
            if (c == 10) check("t5_sum_forced", res_sum, 0);
`else
            check("t5_chk_err", chk_err, 0);
            if (c == 10) check("t5_sum", res_sum, 3);
`endif
            check("t5_res_valid", res_valid, (c == 10));
        end
        do_reset();
        check("t5_chk_err_reset", chk_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
